// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding data-memory responder with byte/half/word
//            lanes, load extension and configurable wait states.
//            Optional macro DMEM_RESP_READY_EN adds resp_ready back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
`ifdef DMEM_RESP_READY_EN
   input  logic        resp_ready,
`endif
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         c_idx_w     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] c_wait_init = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_EXEC = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_funct3;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic               w_accept;
   logic               w_resp_take;
   logic [1:0]         w_lanes;
   logic               w_range_err;
   logic               w_align_err;
   logic               w_f3_err;
   logic               w_err;
   logic [c_idx_w-1:0] w_idx;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata_rep;
   logic [31:0]        w_rd_word;
   logic [31:0]        w_shifted;
   logic [31:0]        w_load;

   assign req_ready = (r_state == S_IDLE) && !rst;
   assign w_accept  = req_valid && req_ready;

`ifdef DMEM_RESP_READY_EN
   assign w_resp_take = resp_ready;
`else
   assign w_resp_take = 1'b1;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = (WAIT_CYCLES == 0) ? S_EXEC : S_WAIT;
         S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_EXEC;
         S_EXEC: w_state_nxt = S_RESP;
         S_RESP: if (w_resp_take) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt <= c_wait_init;
         end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (r_state == S_EXEC) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
         end
      end
   end

   // Request fields need no reset: they are only consumed after an accept.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we     <= req_we;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
         r_funct3 <= req_funct3;
      end
   end

   assign w_lanes     = r_funct3[1:0];
   assign w_range_err = ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign w_align_err = ((w_lanes == 2'b01) && r_addr[0])
                     || ((w_lanes == 2'b10) && (r_addr[1:0] != 2'b00));
   assign w_f3_err    = (w_lanes == 2'b11)
                     || (!r_we && r_funct3[2] && r_funct3[1])
                     || (r_we && r_funct3[2]);
   assign w_err       = w_range_err || w_align_err || w_f3_err;
   assign w_idx       = r_addr[c_idx_w+1:2];

   always_comb begin
      w_be        = 4'b0000;
      w_wdata_rep = r_wdata;
      case (w_lanes)
         2'b00: begin
            w_be        = 4'b0001 << r_addr[1:0];
            w_wdata_rep = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_rep = {2{r_wdata[15:0]}};
         end
         2'b10: begin
            w_be        = 4'b1111;
            w_wdata_rep = r_wdata;
         end
         default: begin
            w_be        = 4'b0000;
            w_wdata_rep = r_wdata;
         end
      endcase
   end

   assign w_rd_word = r_mem[w_idx];
   assign w_shifted = w_rd_word >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_load = 32'd0;
      case (r_funct3)
         3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  w_load = w_shifted;
         3'b100:  w_load = {24'd0, w_shifted[7:0]};
         3'b101:  w_load = {16'd0, w_shifted[15:0]};
         default: w_load = 32'd0;
      endcase
   end

   // Reset in EXEC must abandon the store, hence the !rst term.
   always_ff @(posedge clk) begin
      if (!rst && r_state == S_EXEC && r_we && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
         end
      end
   end

   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = resp_valid ? r_rdata : 32'd0;
   assign resp_err   = resp_valid && r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder (vector table, corner
//            sequences, randomized traffic against a byte-array model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int W0    = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        z_req_valid = 1'b0, z_req_ready, z_req_we = 1'b0;
   logic [31:0] z_req_addr = '0, z_req_wdata = '0;
   logic [2:0]  z_req_funct3 = '0;
   logic        z_resp_valid, z_resp_err;
   logic [31:0] z_resp_rdata;
`ifdef DMEM_RESP_READY_EN
   logic        resp_ready = 1'b1;
   logic        z_resp_ready = 1'b1;
`endif

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
`ifdef DMEM_RESP_READY_EN
      .resp_ready(resp_ready),
`endif
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
      .clk(clk), .rst(rst),
      .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
      .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
`ifdef DMEM_RESP_READY_EN
      .resp_ready(z_resp_ready),
`endif
      .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
   );

   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] mref [4*DEPTH];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] rd;
      logic        err;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input logic [31:0] rd, input logic err);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.rd = rd; v.err = err;
      tbl.push_back(v);
   endfunction

   // Byte-array model: legality from the access rules, data assembled byte by byte.
   function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, output logic [31:0] rd, output logic err);
      int size;
      int a;
      logic [63:0] v;
      size = 1 << f3[1:0];
      err = (f3[1:0] == 2'b11) || ((addr % size) != 0) || (!we && (f3 == 3'd6 || f3 == 3'd7))
         || (we && f3[2]) || ((addr / 4) >= DEPTH);
      rd = 32'd0;
      if (!err) begin
         a = int'(addr);
         if (we) begin
            for (int i = 0; i < size; i++) mref[a+i] = wdata[8*i +: 8];
         end else begin
            v = 64'd0;
            for (int i = 0; i < size; i++) v = v | (64'(mref[a+i]) << (8*i));
            if (!f3[2] && size < 4 && mref[a+size-1][7]) v = v | (64'hFFFF_FFFF << (8*size));
            rd = v[31:0];
         end
      end
   endfunction

   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                      input string nm);
      @(negedge clk);
      chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_funct3 = 3'($urandom);
      for (int k = 1; k <= W0 + 2; k++) begin
         @(negedge clk);
         if (k < W0 + 2) begin
            chk({nm, " early resp_valid"}, 32'(resp_valid), 32'd0);
            chk({nm, " idle resp_rdata"}, resp_rdata, 32'd0);
         end else begin
            chk({nm, " resp_valid"}, 32'(resp_valid), 32'd1);
            chk({nm, " resp_rdata"}, resp_rdata, exp_rd);
            chk({nm, " resp_err"}, 32'(resp_err), 32'(exp_err));
         end
      end
   endtask

   // extra=0 asserts reset while in WAIT, extra=1 while in EXEC.
   task automatic rst_mid(input logic [31:0] addr, input logic [31:0] wdata, input int extra,
                          input string nm);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata; req_funct3 = 3'd2;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (extra) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk({nm, " ready in rst"}, 32'(req_ready), 32'd0);
      chk({nm, " valid in rst"}, 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk({nm, " ready after rst"}, 32'(req_ready), 32'd1);
      repeat (3) begin
         chk({nm, " no resp"}, 32'(resp_valid), 32'd0);
         @(negedge clk);
      end
   endtask

   initial begin
      logic        r_we;
      logic [31:0] r_a, r_d, e_rd;
      logic [2:0]  r_f3;
      logic        e_err;

      add(1, 32'h10,  32'hDEADBEEF, 3'd2, 32'h0,        0);
      add(0, 32'h10,  32'h0,        3'd2, 32'hDEADBEEF, 0);
      add(1, 32'h20,  32'h11223344, 3'd2, 32'h0,        0);
      add(1, 32'h21,  32'h000000A5, 3'd0, 32'h0,        0);
      add(0, 32'h20,  32'h0,        3'd2, 32'h1122A544, 0);
      add(0, 32'h21,  32'h0,        3'd0, 32'hFFFFFFA5, 0);
      add(0, 32'h21,  32'h0,        3'd4, 32'h000000A5, 0);
      add(1, 32'h30,  32'h00005555, 3'd2, 32'h0,        0);
      add(1, 32'h32,  32'h00008001, 3'd1, 32'h0,        0);
      add(0, 32'h32,  32'h0,        3'd1, 32'hFFFF8001, 0);
      add(0, 32'h32,  32'h0,        3'd5, 32'h00008001, 0);
      add(0, 32'h30,  32'h0,        3'd2, 32'h80015555, 0);
      add(1, 32'h00,  32'hCAFEF00D, 3'd2, 32'h0,        0);
      add(0, 32'h13,  32'h0,        3'd2, 32'h0,        1);
      add(0, 32'h41,  32'h0,        3'd1, 32'h0,        1);
      add(1, 32'h100, 32'hBAD0BAD0, 3'd2, 32'h0,        1);
      add(0, 32'h10,  32'h0,        3'd2, 32'hDEADBEEF, 0);
      add(0, 32'h00,  32'h0,        3'd2, 32'hCAFEF00D, 0);
      add(1, 32'h10,  32'h0,        3'd4, 32'h0,        1);
      add(0, 32'h10,  32'h0,        3'd6, 32'h0,        1);
      add(0, 32'h10,  32'h0,        3'd3, 32'h0,        1);
      add(1, 32'h13,  32'h00000077, 3'd0, 32'h0,        0);
      add(0, 32'h10,  32'h0,        3'd2, 32'h77ADBEEF, 0);
      add(0, 32'h13,  32'h0,        3'd0, 32'h00000077, 0);
      add(0, 32'h12,  32'h0,        3'd1, 32'h000077AD, 0);
      add(0, 32'h10,  32'h0,        3'd1, 32'hFFFFBEEF, 0);
      add(1, 32'h50,  32'h0BADF00D, 3'd2, 32'h0,        0);
      add(1, 32'h54,  32'h01020304, 3'd2, 32'h0,        0);
      add(1, 32'h33,  32'hFFFFFFFF, 3'd1, 32'h0,        1);
      add(0, 32'h30,  32'h0,        3'd2, 32'h80015555, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", 32'(req_ready), 32'd0);
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset resp_rdata", resp_rdata, 32'd0);
      chk("reset resp_err", 32'(resp_err), 32'd0);
      chk("reset z req_ready", 32'(z_req_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post-reset req_ready", 32'(req_ready), 32'd1);
      chk("post-reset z req_ready", 32'(z_req_ready), 32'd1);

      foreach (tbl[i])
         txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, tbl[i].rd, tbl[i].err,
             $sformatf("vec%0d", i));

      rst_mid(32'h50, 32'h12345678, 0, "rst_wait");
      txn(0, 32'h50, 32'h0, 3'd2, 32'h0BADF00D, 0, "after rst_wait");
      rst_mid(32'h54, 32'hFFFFFFFF, 1, "rst_exec");
      txn(0, 32'h54, 32'h0, 3'd2, 32'h01020304, 0, "after rst_exec");

      // Zero-wait instance with req_valid held high: stores then loads of 0x8.
      @(negedge clk);
      z_req_valid = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (c > 0) @(negedge clk);
         z_req_we = (c < 9); z_req_addr = 32'h8; z_req_wdata = 32'(c); z_req_funct3 = 3'd2;
         chk($sformatf("b2b ready c%0d", c), 32'(z_req_ready), 32'((c % 3) == 0));
         chk($sformatf("b2b valid c%0d", c), 32'(z_resp_valid), 32'((c % 3) == 2));
         if ((c % 3) == 2) begin
            chk($sformatf("b2b rdata c%0d", c), z_resp_rdata, (c >= 11) ? 32'd6 : 32'd0);
            chk($sformatf("b2b err c%0d", c), 32'(z_resp_err), 32'd0);
         end
      end
      z_req_valid = 1'b0;

`ifdef DMEM_RESP_READY_EN
      @(negedge clk);
      z_resp_ready = 1'b0;
      z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h8; z_req_funct3 = 3'd2;
      @(posedge clk);
      #1 z_req_valid = 1'b0;
      @(negedge clk);
      repeat (4) begin
         @(negedge clk);
         chk("hold valid", 32'(z_resp_valid), 32'd1);
         chk("hold rdata", z_resp_rdata, 32'd6);
         chk("hold ready", 32'(z_req_ready), 32'd0);
      end
      z_resp_ready = 1'b1;
      @(negedge clk);
      chk("release valid", 32'(z_resp_valid), 32'd0);
      chk("release ready", 32'(z_req_ready), 32'd1);
`endif

      for (int w = 0; w < DEPTH; w++) begin
         r_d = $urandom;
         model(1'b1, 32'(4*w), r_d, 3'd2, e_rd, e_err);
         txn(1'b1, 32'(4*w), r_d, 3'd2, e_rd, e_err, $sformatf("preset%0d", w));
      end

      for (int i = 0; i < 200; i++) begin
         r_we = 1'($urandom_range(0, 1));
         r_f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) r_a = $urandom;
         else r_a = 32'($urandom_range(0, 4*DEPTH-1));
         r_d = $urandom;
         model(r_we, r_a, r_d, r_f3, e_rd, e_err);
         txn(r_we, r_a, r_d, r_f3, e_rd, e_err, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the execute stage's load/store address path.
- Accepts one request at a time: effective address (rs1+imm), store data and funct3.
- Performs word-addressed RAM access with byte/half/word lanes and load sign or zero extension.
- Returns read data or an error after a configurable number of wait states. The pipeline stalls on req_ready/resp_valid.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM; a power of two, at least 2.
WAIT_CYCLES, 1, extra cycles between request accept and response; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data; the byte/half is taken from the low bits.
req_funct3  input  3  RISC-V load/store funct3.
resp_valid  output  1  response present.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  misaligned, illegal funct3, or out-of-range request.

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is rst.
- While rst=1 or on the cycle after it: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
- RAM contents are not reset.
- req_ready = (state==IDLE) && !rst, combinational.
- Handshake: a request is accepted on the edge where req_valid && req_ready. All request fields are latched then; the inputs are don't-care afterwards.
- States:
  - IDLE -> WAIT on accept, counter = WAIT_CYCLES-1; IDLE -> EXEC if WAIT_CYCLES==0.
  - WAIT decrements the counter and goes to EXEC when it reaches 0.
  - EXEC performs the access and registers the response, then goes to RESP.
  - RESP drives resp_valid=1 for exactly one cycle, then returns to IDLE.
- Latency: resp_valid rises WAIT_CYCLES+2 cycles after the accept edge. Throughput is one request per WAIT_CYCLES+3 cycles.
- Error conditions (resp_err=1, no RAM write, resp_rdata=0):
  - funct3 lanes 01 (half) with addr[0]=1.
  - funct3 lanes 10 (word) with addr[1:0]!=0.
  - funct3[1:0]==11.
  - Loads with funct3 110 or 111.
  - Stores with funct3[2]=1.
  - Word index addr[31:2] >= DEPTH_WORDS.
- Stores (SB 000, SH 001, SW 010):
  - Byte enables come from addr[1:0] and size.
  - The data byte/half is replicated into the selected lane.
  - The write commits in EXEC; a following load sees the new data.
- Loads:
  - The word is read in EXEC and shifted right by 8*addr[1:0].
  - LB/LH sign-extend; LW passes the word through; LBU/LHU zero-extend.
- resp_rdata and resp_err hold their value only during RESP. Outside RESP they read 0.
- Reset mid-operation (WAIT or EXEC): the request is abandoned, there is no write and no response, and the block returns to IDLE.

Optional Feature:
Macro DMEM_RESP_READY_EN.
- Defined: adds input port resp_ready (1 bit).
  - RESP holds resp_valid, resp_rdata and resp_err stable until resp_ready=1, then goes to IDLE on that edge.
  - req_ready stays 0 while a response is unconsumed.
- Undefined: no resp_ready port; the response is a single-cycle pulse that the consumer must sample.

Test Plan:
1. WAIT_CYCLES=1. SW addr 0x10, data 0xDEADBEEF, then LW addr 0x10 -> each resp_valid 3 cycles after its accept; load resp_rdata=0xDEADBEEF, resp_err=0.
2. SB addr 0x21, data 0x000000A5 over a word preset to 0x11223344 -> word becomes 0x1122A544. Then LB 0x21 -> 0xFFFFFFA5; LBU 0x21 -> 0x000000A5.
3. SH addr 0x32, data 0x8001, then LH 0x32 -> 0xFFFF8001; LHU 0x32 -> 0x00008001.
4. LW addr 0x13, LH addr 0x41, and SW at byte address 4*DEPTH_WORDS -> resp_err=1 and resp_rdata=0 for each; the RAM word at 0x10 is unchanged.
5. Assert rst in WAIT during SW addr 0x50, data 0x12345678 -> no resp_valid; a later LW 0x50 returns the old contents. req_ready=0 during rst and 1 on the first cycle after.
6. WAIT_CYCLES=0, back-to-back requests with req_valid held high -> accepts exactly every 3 cycles and resp_valid 2 cycles after each accept. With DMEM_RESP_READY_EN and resp_ready held 0 for 4 cycles -> the response stays stable and req_ready stays 0.
